// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_iter
// Brief    : Iterative AES inverse cipher (AES-128/192/256) sharing one
//            inverse-round datapath; round keys fetched by index from an
//            external key store. Define AES_DEC_ABORT_EN to add an abort input.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_iter #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef AES_DEC_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      data_out,
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [127:0]      rk_data,
    output logic              busy
);

    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
        end
        if ((2 ** KIDX_W) <= NR) begin : g_bad_kidx
            $error("aes_inv_cipher_iter: KIDX_W too narrow for NR");
        end
    endgenerate

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_round = 2'd1;
    localparam logic [1:0] c_final = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [KIDX_W-1:0] c_nr    = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] c_nr_m1 = KIDX_W'(NR - 1);
    localparam logic [KIDX_W-1:0] c_one   = KIDX_W'(1);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8) as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        logic [7:0] sq;
        logic [7:0] r;
        a  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [127:0]      r_st_reg;
    logic [127:0]      w_st_nxt;
    logic [KIDX_W-1:0] r_cnt;
    logic [KIDX_W-1:0] w_cnt_nxt;
    logic [127:0]      w_ark;
    logic [127:0]      w_imc;

    assign w_ark = inv_shift_sub(r_st_reg) ^ rk_data;
    assign w_imc = inv_mix(w_ark);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_st_reg <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_st_reg <= w_st_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st_reg;
        w_cnt_nxt   = r_cnt;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        rk_idx      = c_nr;
        case (r_state)
            c_idle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_st_nxt    = data_in ^ rk_data;
                    w_cnt_nxt   = c_nr_m1;
                    w_state_nxt = c_round;
                end
            end
            c_round: begin
                busy      = 1'b1;
                rk_idx    = r_cnt;
                w_st_nxt  = w_imc;
                w_cnt_nxt = r_cnt - c_one;
                if (r_cnt == c_one) w_state_nxt = c_final;
            end
            c_final: begin
                busy        = 1'b1;
                rk_idx      = '0;
                w_st_nxt    = w_ark;
                w_state_nxt = c_done;
            end
            c_done: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_st_nxt    = '0;
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
`ifdef AES_DEC_ABORT_EN
        if (abort && (r_state != c_idle)) begin
            w_state_nxt = c_idle;
            w_st_nxt    = '0;
            w_cnt_nxt   = '0;
        end
`endif
    end

    // Plaintext is only exposed while the handshake is offered.
    assign data_out = out_valid ? r_st_reg : '0;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_inv_cipher_iter
// Brief    : Self-checking bench for aes_inv_cipher_iter at NR=10/12/14 with a
//            key-RAM model; abort sequence built when AES_DEC_ABORT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_iter;

    typedef struct {
        int           nr;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           hold;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        iv, ordy, ir, ov, busy;
    logic [2:0][127:0] din, dout, rkd;
    logic [2:0][3:0]   idx;
`ifdef AES_DEC_ABORT_EN
    logic [2:0]        abrt;
`endif
    logic [127:0]      kr [0:15];
    logic [7:0]        sbox [0:255];
    logic [127:0]      exp_q [$];
    vec_t              vecs [5];
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            assign rkd[g] = kr[idx[g]];
            aes_inv_cipher_iter #(.NR(10 + 2*g), .KIDX_W(4)) u_dut (
                .clk      (clk),
                .rst      (rst),
`ifdef AES_DEC_ABORT_EN
                .abort    (abrt[g]),
`endif
                .in_valid (iv[g]),
                .in_ready (ir[g]),
                .data_in  (din[g]),
                .out_valid(ov[g]),
                .out_ready(ordy[g]),
                .data_out (dout[g]),
                .rk_idx   (idx[g]),
                .rk_data  (rkd[g]),
                .busy     (busy[g])
            );
        end
    endgenerate

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box entry: brute-force GF inverse followed by the affine map.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] v;
        v = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gm(b, 8'(y)) == 8'h01) v = 8'(y);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) kr[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic wait_idle(input int s);
        for (int n = 0; n < 40 && !ir[s]; n++) begin
            @(posedge clk); #1;
        end
        chk("idle_wait", ir[s], 1);
    endtask

    task automatic run_vec(input vec_t v);
        int           s, lat;
        logic         seq_ok, stable;
        logic [127:0] held, want;
        s = (v.nr - 10) / 2;
        expand(v.key, v.nr);
        wait_idle(s);
        @(negedge clk);
        chk("idx_at_accept", 128'(idx[s]), 128'(v.nr));
        iv[s]  = 1'b1;
        din[s] = v.ct;
        exp_q.push_back(v.pt);
        @(posedge clk); #1;
        iv[s]  = 1'b0;
        din[s] = {$urandom, $urandom, $urandom, $urandom};
        seq_ok = (idx[s] == 4'(v.nr - 1)) && busy[s] && !ir[s];
        lat = -1;
        for (int n = 1; n <= v.nr + 4 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (ov[s]) begin
                lat = n;
                if (idx[s] != 4'(v.nr) || busy[s] || ir[s]) seq_ok = 1'b0;
            end else if (idx[s] != ((n == v.nr - 1) ? 4'd0 : 4'(v.nr - 1 - n))) begin
                seq_ok = 1'b0;
            end
        end
        chk("latency", 128'(lat), 128'(v.nr));
        chk("rk_idx_seq", seq_ok, 1);
        want = exp_q.pop_front();
        chk("data_out", dout[s], want);
        held   = dout[s];
        stable = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            if (dout[s] !== held || ir[s] || !ov[s]) stable = 1'b0;
        end
        if (v.hold > 0) chk("hold_stable", stable, 1);
        // A block offered in the handshake cycle must not be taken.
        @(negedge clk);
        ordy[s] = 1'b1;
        iv[s]   = 1'b1;
        din[s]  = v.ct;
        @(posedge clk); #1;
        ordy[s] = 1'b0;
        iv[s]   = 1'b0;
        chk("ov_after_hs", ov[s], 0);
        chk("dout_after_hs", dout[s], 0);
        chk("ready_after_hs", ir[s], 1);
    endtask

    initial begin
        logic seen;
        iv = '0; ordy = '0; din = '0;
`ifdef AES_DEC_ABORT_EN
        abrt = '0;
`endif
        for (int i = 0; i < 256; i++) sbox[i] = fwd_sbox(8'(i));
        vecs[0] = '{10, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 5};
        vecs[1] = '{10, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 0};
        vecs[2] = '{12, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff, 2};
        vecs[3] = '{14, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, 0};
        vecs[4] = vecs[0];
        vecs[4].hold = 0;
        expand(vecs[0].key, 14);

        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_in_ready", ir[g], 1);
            chk("rst_out_valid", ov[g], 0);
            chk("rst_data_out", dout[g], 0);
            chk("rst_busy", busy[g], 0);
            chk("rst_rk_idx", 128'(idx[g]), 128'(10 + 2*g));
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset in the fourth ROUND cycle abandons the block.
        expand(vecs[0].key, 10);
        wait_idle(0);
        @(negedge clk);
        iv[0] = 1'b1;
        din[0] = vecs[0].ct;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", ov[0], 0);
        chk("midrst_in_ready", ir[0], 1);
        chk("midrst_data_out", dout[0], 0);
        chk("midrst_rk_idx", 128'(idx[0]), 128'd10);
        chk("midrst_busy", busy[0], 0);
        seen = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        chk("midrst_no_output", seen, 0);

`ifdef AES_DEC_ABORT_EN
        // Abort in IDLE is ignored; abort in FINAL wins over out_ready.
        wait_idle(0);
        @(negedge clk);
        iv[0] = 1'b1;
        abrt[0] = 1'b1;
        din[0] = vecs[0].ct;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        abrt[0] = 1'b0;
        chk("abort_idle_ignored", busy[0], 1);
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("abort_in_final", 128'({busy[0], idx[0]}), 128'h10);
        abrt[0] = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        abrt[0] = 1'b0;
        ordy[0] = 1'b0;
        chk("abort_in_ready", ir[0], 1);
        chk("abort_out_valid", ov[0], 0);
        chk("abort_busy", busy[0], 0);
        seen = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        chk("abort_no_output", seen, 0);
`endif

        run_vec(vecs[1]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
